// File: rtl/fft_frame_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// fft_frame_scheduler_pkg
// Shared constants, state encoding and the twiddle index helper for the
// 64-point radix-2 FFT frame scheduler. The butterfly core and the output
// counter import the same package, so they always agree on frame geometry.
//   N        points per frame (power of two)
//   LOG2N    log2(N); width of the sample RAM address
//   PIPE_LAT butterfly pipeline depth; drain cycles between stages (>= 1)
// -----------------------------------------------------------------------------
package fft_frame_scheduler_pkg;

    localparam int N        = 64;
    localparam int LOG2N    = 6;
    localparam int PIPE_LAT = 2;
    localparam int TW_W     = LOG2N - 1;
    localparam int DRAIN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HANDOFF = 3'd4
    } state_e;

    // Decimation-in-time twiddle index: (j mod 2^stage) << (LOG2N-1-stage).
    // The shift result is truncated to TW_W bits by the return type.
    function automatic logic [TW_W-1:0] twiddle_index(input logic [2:0]      stage,
                                                      input logic [TW_W-1:0] j);
        logic [LOG2N-1:0] span;
        logic [TW_W-1:0]  masked;
        logic [2:0]       shamt;
        span   = LOG2N'(1) << stage;
        masked = j & TW_W'(span - LOG2N'(1));
        shamt  = 3'(TW_W) - stage;
        return masked << shamt;
    endfunction

endpackage

// File: rtl/fft_twiddle_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_twiddle_addr_gen
// Maps (stage, butterfly index j) to the twiddle ROM index and registers it.
// When en is low the registered index is forced to 0.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   en           in   index is meaningful this cycle (butterfly enabled)
//   stage        in   butterfly stage 0..LOG2N-1
//   j            in   butterfly index within the stage
//   twiddle_addr out  registered twiddle ROM index
// -----------------------------------------------------------------------------
module fft_twiddle_addr_gen
    import fft_frame_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2:0]      stage,
    input  logic [TW_W-1:0] j,
    output logic [TW_W-1:0] twiddle_addr
);

    logic [TW_W-1:0] tw_d;
    logic [TW_W-1:0] tw_q;

    always_comb begin
        tw_d = '0;
        if (en) begin
            tw_d = twiddle_index(stage, j);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tw_q <= '0;
        end else begin
            tw_q <= tw_d;
        end
    end

    assign twiddle_addr = tw_q;

endmodule

// File: rtl/fft_frame_scheduler.sv
// -----------------------------------------------------------------------------
// fft_frame_scheduler
// Sequencer of the 64-point radix-2 FFT core: loads one frame of N samples,
// steps the butterfly datapath through LOG2N stages (with PIPE_LAT drain
// cycles after each), then hands the frame to the output counter with a
// one-cycle dataind pulse, held off while the output counter is still busy.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request a new frame (only looked at in IDLE)
//   din_valid     input sample present
//   din_ready     scheduler accepts a sample (LOAD)
//   load_en       sample RAM write strobe (combinational)
//   in_addr       sample RAM write address
//   stage         current butterfly stage
//   stage_en      butterfly datapath enable (COMPUTE)
//   bfly_addr     butterfly index within the stage
//   twiddle_addr  twiddle ROM index for (stage, bfly_addr)
//   hold_all      freeze datapath registers (IDLE, LOAD, HANDOFF)
//   out_busy      output counter still streaming the previous frame
//   dataind       one-cycle frame-ready pulse
//   busy          high in every state except IDLE
//   fsm_state     current FSM state, for observation
// All outputs except load_en come straight from flops.
// -----------------------------------------------------------------------------
module fft_frame_scheduler
    import fft_frame_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             load_en,
    output logic [LOG2N-1:0] in_addr,
    output logic [2:0]       stage,
    output logic             stage_en,
    output logic [TW_W-1:0]  bfly_addr,
    output logic [TW_W-1:0]  twiddle_addr,
    output logic             hold_all,
    input  logic             out_busy,
    output logic             dataind,
    output logic             busy,
    output state_e           fsm_state
);

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   in_addr_q, in_addr_d;
    logic [2:0]         stage_q, stage_d;
    logic [TW_W-1:0]    bfly_q, bfly_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               dataind_q, dataind_d;
    logic               din_ready_q, stage_en_q, hold_all_q, busy_q;

    // Sample handshake: a sample transfers on a rising edge where din_valid
    // and din_ready are both high; din_valid may be low for any number of
    // cycles without penalty.
    assign load_en = din_valid & din_ready_q;

    always_comb begin
        state_d   = state_q;
        in_addr_d = in_addr_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        drain_d   = drain_q;
        dataind_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    in_addr_d = '0;
                end
            end
            ST_LOAD: begin
                if (load_en) begin
                    in_addr_d = in_addr_q + LOG2N'(1);
                    if (in_addr_q == LOG2N'(N - 1)) begin
                        state_d = ST_COMPUTE;
                        stage_d = '0;
                        bfly_d  = '0;
                    end
                end
            end
            ST_COMPUTE: begin
                bfly_d = bfly_q + TW_W'(1);
                if (bfly_q == TW_W'(N / 2 - 1)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
                    if (stage_q == 3'(LOG2N - 1)) begin
                        state_d = ST_HANDOFF;
                        // Output counter idle already: the pulse lands in
                        // the first HANDOFF cycle.
                        dataind_d = ~out_busy;
                    end else begin
                        state_d = ST_COMPUTE;
                        stage_d = stage_q + 3'd1;
                        bfly_d  = '0;
                    end
                end
            end
            ST_HANDOFF: begin
                // The cycle carrying the pulse is the last HANDOFF cycle;
                // start is therefore only seen from the following IDLE cycle.
                if (dataind_q) begin
                    state_d = ST_IDLE;
                end else begin
                    dataind_d = ~out_busy;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_addr_q   <= '0;
            stage_q     <= '0;
            bfly_q      <= '0;
            drain_q     <= '0;
            dataind_q   <= 1'b0;
            din_ready_q <= 1'b0;
            stage_en_q  <= 1'b0;
            hold_all_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_addr_q   <= in_addr_d;
            stage_q     <= stage_d;
            bfly_q      <= bfly_d;
            drain_q     <= drain_d;
            dataind_q   <= dataind_d;
            din_ready_q <= (state_d == ST_LOAD);
            stage_en_q  <= (state_d == ST_COMPUTE);
            hold_all_q  <= (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
                           (state_d == ST_HANDOFF);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    // Fed with next-state values so its registered output lines up with
    // bfly_addr and stage_en.
    fft_twiddle_addr_gen u_twiddle (
        .clk          (clk),
        .rst          (rst),
        .en           (state_d == ST_COMPUTE),
        .stage        (stage_d),
        .j            (bfly_d),
        .twiddle_addr (twiddle_addr)
    );

    assign din_ready = din_ready_q;
    assign in_addr   = in_addr_q;
    assign stage     = stage_q;
    assign stage_en  = stage_en_q;
    assign bfly_addr = bfly_q;
    assign hold_all  = hold_all_q;
    assign dataind   = dataind_q;
    assign busy      = busy_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
module tb_fft_frame_scheduler;

    localparam int N        = 64;
    localparam int LOG2N    = 6;
    localparam int PIPE_LAT = 2;
    // Cycle numbering: the cycle in which start is sampled is cycle 1.
    localparam int COMP_CYC = LOG2N * (N / 2 + PIPE_LAT);
    localparam int LAT      = N + COMP_CYC + 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       din_valid = 1'b0;
    logic       out_busy = 1'b0;
    logic       din_ready, load_en, stage_en, hold_all, dataind, busy;
    logic [5:0] in_addr;
    logic [2:0] stage;
    logic [4:0] bfly_addr, twiddle_addr;
    logic [2:0] fsm_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_frame_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .load_en      (load_en),
        .in_addr      (in_addr),
        .stage        (stage),
        .stage_en     (stage_en),
        .bfly_addr    (bfly_addr),
        .twiddle_addr (twiddle_addr),
        .hold_all     (hold_all),
        .out_busy     (out_busy),
        .dataind      (dataind),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [5:0]  exp_addr_q[$];
    logic [12:0] exp_bfly_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ready_total = 0;
    int          dataind_cnt = 0;
    int          first_en_cyc = 0;
    int          di_cyc = 0;
    int          start_cyc = 0;
    int          ready0 = 0;
    int          gap = 0;
    logic        gap_open = 1'b0;
    logic        prev_en = 1'b0;
    logic [2:0]  last_stage = 3'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic reset_checks();
        check("rst_state",    32'(fsm_state), 0);
        check("rst_in_addr",  32'(in_addr), 0);
        check("rst_stage",    32'(stage), 0);
        check("rst_bfly",     32'(bfly_addr), 0);
        check("rst_twiddle",  32'(twiddle_addr), 0);
        check("rst_din_rdy",  32'(din_ready), 0);
        check("rst_stage_en", 32'(stage_en), 0);
        check("rst_dataind",  32'(dataind), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_hold_all", 32'(hold_all), 1);
    endtask

    // Expected butterfly/twiddle sequence for one full frame.
    task automatic push_compute();
        for (int s = 0; s < LOG2N; s++) begin
            for (int j = 0; j < N / 2; j++) begin
                int tw;
                tw = ((j % (1 << s)) << (LOG2N - 1 - s)) % (N / 2);
                exp_bfly_q.push_back({3'(s), 5'(j), 5'(tw)});
            end
        end
    endtask

    // ---------------- monitor ----------------
    task automatic monitor_loop();
        logic [5:0]  ea;
        logic [12:0] eb;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_addr_q.delete();
                exp_bfly_q.delete();
                gap_open = 1'b0;
                prev_en  = 1'b0;
            end else begin
                if (din_ready) ready_total++;
                if (load_en) begin
                    if (exp_addr_q.size() == 0) begin
                        check("addr_q_underrun", 32'(exp_addr_q.size()), 1);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("in_addr", 32'(in_addr), 32'(ea));
                    end
                end
                if (stage_en) begin
                    if (!prev_en && stage == 3'd0) first_en_cyc = cyc;
                    if (!prev_en && gap_open) begin
                        check("drain_gap", 32'(gap), PIPE_LAT);
                        gap_open = 1'b0;
                    end
                    if (exp_bfly_q.size() == 0) begin
                        check("bfly_q_underrun", 32'(exp_bfly_q.size()), 1);
                    end else begin
                        eb = exp_bfly_q.pop_front();
                        check("stage_bfly_tw", 32'({stage, bfly_addr, twiddle_addr}), 32'(eb));
                    end
                    if (stage == 3'd5 && bfly_addr == 5'd17) check("tw_s5_j17", 32'(twiddle_addr), 17);
                    if (stage == 3'd2 && bfly_addr == 5'd6)  check("tw_s2_j6", 32'(twiddle_addr), 16);
                end else begin
                    check("tw_idle_zero", 32'(twiddle_addr), 0);
                    if (prev_en) begin
                        gap      = 1;
                        gap_open = (last_stage != 3'(LOG2N - 1));
                    end else if (gap_open) begin
                        gap++;
                    end
                end
                if (dataind) begin
                    dataind_cnt++;
                    di_cyc = cyc;
                end
                prev_en    = stage_en;
                last_stage = stage;
            end
        end
    endtask

    // ---------------- drivers ----------------
    // mode 0: din_valid always 1; 1: alternating 1,0,...; 2: random
    task automatic run_frame(input int mode, output int load_cycles);
        int sent;
        int k;
        logic v;
        ready0 = ready_total;
        @(posedge clk); #1;
        start     = 1'b1;
        din_valid = (mode == 0);
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        sent = 0;
        k    = 0;
        while (sent < N) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (k % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            din_valid = v;
            if (v) begin
                exp_addr_q.push_back(6'(sent));
                sent++;
                if (sent == N) push_compute();
            end
            @(posedge clk); #1;
            k++;
        end
        din_valid   = 1'b0;
        load_cycles = k;
    endtask

    task automatic wait_dataind(input int budget);
        int n0;
        int t;
        n0 = dataind_cnt;
        t  = 0;
        while (dataind_cnt == n0 && t < budget) begin
            @(negedge clk); #1;
            t++;
        end
        check("dataind_seen", 32'(dataind_cnt - n0), 1);
    endtask

    task automatic wait_handoff(input int budget);
        int t;
        t = 0;
        while (fsm_state != 3'd4 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("reach_handoff", 32'(fsm_state), 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int k;
        int n0;
        int drop_cyc;
        logic found;
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk); #1 rst = 1'b0;

        // Full frame, valid held high, output counter idle.
        run_frame(0, k);
        wait_dataind(2000);
        check("ready_cycles_t1", 32'(ready_total - ready0), N);
        check("first_stage_en",  32'(first_en_cyc - start_cyc + 2), N + 2);
        check("dataind_latency", 32'(di_cyc - start_cyc + 2), LAT);
        check("busy_at_dataind", 32'(busy), 1);
        @(negedge clk); #1;
        check("dataind_single",  32'(dataind), 0);
        check("busy_fall",       32'(busy), 0);
        check("idle_after",      32'(fsm_state), 0);

        // Output counter busy at handoff; start raised while waiting.
        out_busy = 1'b1;
        run_frame(2, k);
        check("ready_cycles_t4", 32'(ready_total - ready0), 32'(k));
        wait_handoff(2000);
        n0 = dataind_cnt;
        @(posedge clk); #1 start = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("held_no_dataind", 32'(dataind_cnt - n0), 0);
        check("held_state",      32'(fsm_state), 4);
        check("held_busy",       32'(busy), 1);
        check("held_hold_all",   32'(hold_all), 1);
        check("held_stage_en",   32'(stage_en), 0);
        @(posedge clk); #1;
        out_busy = 1'b0;
        drop_cyc = cyc;
        wait_dataind(20);
        start = 1'b0;
        check("release_latency", 32'(di_cyc - drop_cyc), 1);
        @(negedge clk); #1;
        check("release_idle",    32'(fsm_state), 0);
        check("release_busy",    32'(busy), 0);
        repeat (3) @(negedge clk);
        #1;
        check("start_ignored",   32'(fsm_state), 0);

        // Alternating valid: 64 accepted samples over 127 LOAD cycles.
        run_frame(1, k);
        wait_dataind(2000);
        check("toggle_ready",    32'(ready_total - ready0), 2 * N - 1);
        check("toggle_first_en", 32'(first_en_cyc - start_cyc), 2 * N - 1);
        check("toggle_latency",  32'(di_cyc - start_cyc), 2 * N - 1 + COMP_CYC);

        // Reset in the middle of stage 3.
        run_frame(2, k);
        found = 1'b0;
        for (int t = 0; t < 1000 && !found; t++) begin
            @(negedge clk);
            if (stage_en && stage == 3'd3 && bfly_addr == 5'd10) found = 1'b1;
        end
        check("reach_s3_j10", 32'(found), 1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        reset_checks();
        @(negedge clk); #1 rst = 1'b0;
        n0 = dataind_cnt;
        repeat (300) @(negedge clk);
        #1;
        check("no_dataind_after_rst", 32'(dataind_cnt - n0), 0);
        check("idle_after_rst",       32'(fsm_state), 0);

        run_frame(0, k);
        wait_dataind(2000);
        check("post_rst_latency", 32'(di_cyc - start_cyc + 2), LAT);
        @(negedge clk); #1;
        check("addr_q_empty", 32'(exp_addr_q.size()), 0);
        check("bfly_q_empty", 32'(exp_bfly_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
